show_frame_uart_tx: RTL and testbench
=====================================

# show_frame_uart_tx

Serializes the 128-bit debug/trace frames produced by the processor top level (`tx_show` / `show_len`) onto a UART line. Each frame is transmitted byte-by-byte, most-significant meaningful byte first. Frames arriving while a transmission is in progress are dropped and counted, never stalled, because the processor-side trace tap cannot apply back-pressure. The block sits between the top level's trace outputs and the board's UART TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `DROP_W`, 16, width of the dropped-frame counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `frame_data`  in  128  frame payload, right-aligned: the meaningful bytes are the low `frame_len` bytes.
- `frame_len`  in  5  number of bytes to send, 0..16.
- `frame_valid`  in  1  frame offered this cycle.
- `frame_ready`  out  1  high iff the FSM is in IDLE (combinational from state).
- `txd`  out  1  UART serial output, registered, idle high.
- `busy`  out  1  high when not in IDLE.
- `drop_cnt`  out  `DROP_W`  saturating count of offered-but-rejected frames.

## Operation
- Acceptance: at a posedge with `frame_valid & frame_ready`, the block latches `frame_data` into the shift register and the clamped length into the byte counter.
- Length rules: `frame_len` = 0 → frame consumed, FSM stays IDLE, `txd` untouched. `frame_len` > 16 → treated as 16.
- Byte order: the first byte sent is `frame_data[8*L-1 -: 8]`, then descending, and the last is `frame_data[7:0]` (L = clamped length).
- Byte format: 1 start bit (0), 8 data bits LSB-first, optional parity (see Configuration), 1 stop bit (1).
- States and transitions:
  - IDLE → START on accept with L > 0.
  - START → DATA after 1 bit time.
  - DATA → PARITY (if enabled) or STOP after 8 bit times.
  - PARITY → STOP after 1 bit time.
  - STOP → START if bytes remain; otherwise STOP → IDLE.
  - Bytes are back-to-back, with no idle gap between them.
- Drop: a posedge with `frame_valid & ~frame_ready` increments `drop_cnt`. The counter saturates at all-ones and never wraps. The offered frame is discarded.
- Frame data is captured once. Changes to `frame_data` / `frame_len` mid-transmission have no effect.
- Reset, including mid-frame: `txd`=1, `busy`=0, `frame_ready`=1, `drop_cnt`=0, FSM=IDLE, all counters cleared. The partial byte is abandoned.

## Timing
- The `txd` register updates at the acceptance edge, so `txd`=0 (start bit) begins immediately after that edge.
- Each bit lasts exactly `CLKS_PER_BIT` cycles, timed by a baud counter that restarts at every bit boundary.
- Frame duration: L × B × `CLKS_PER_BIT` cycles, where B = 10 (11 with parity). `busy` is high for exactly that many cycles.
- At the edge ending the last stop bit the FSM enters IDLE. `frame_ready` rises in the following cycle, and the earliest next acceptance is that cycle's closing edge.
- `frame_valid` asserted on the final STOP cycle counts as a drop.
- There is no combinational path from inputs to `txd`.

## Configuration
- Macro `SHOW_TX_PARITY_EN`.
- Defined: an even-parity bit is inserted after data bit 7 and before the stop bit. Its value is the XOR of the 8 data bits, and B = 11.
- Undefined: there is no PARITY state and B = 10.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and a decoding UART monitor on `txd`.
- Single-byte frame: `frame_len`=1, `frame_data`=128'h80 → bits 0,0000000 1,1 (start, 0x80 LSB-first, stop). `busy` is high for 40 cycles (44 with parity).
- Twelve-byte frame: `frame_len`=12, low 96 bits = 96'h10_05_3C_00_00000040_8C020000 → monitor receives 10 05 3C 00 00 00 00 40 8C 02 00 00 back-to-back, in 480 cycles.
- Length edge cases:
  - `frame_len`=0 → `txd` stays high and `busy` stays 0.
  - `frame_len`=20 with 128'h0F0E…00 → 16 bytes sent, 0F first, 00 last.
- Drops: hold `frame_valid` high continuously through a 2-byte frame → exactly one frame sent; `drop_cnt` = number of busy cycles (80). Force the counter near all-ones → it sticks at 16'hFFFF.
- Reset mid-byte: assert `reset` during DATA bit 3 → `txd`=1, `frame_ready`=1, `drop_cnt`=0 immediately. A new frame after reset transmits correctly.
- Parity build (`SHOW_TX_PARITY_EN`): byte 0x07 → parity bit 1; byte 0x03 → parity bit 0.

Source files
------------

// File: rtl/show_frame_uart_tx_if.sv
// ---------------------------------------------------------------------------
// show_frame_uart_tx_if
// Trace-frame offer channel between the processor top level and the UART
// frame serializer. The producer (master) offers a frame and cannot stall;
// the serializer (slave) reports whether it can take the frame this cycle.
//
// Signals:
//   frame_data  [127:0] frame payload, right-aligned (low frame_len bytes)
//   frame_len   [4:0]   number of bytes to send, 0..16 (larger values clamp)
//   frame_valid         frame offered this cycle
//   frame_ready         serializer is idle and will take an offered frame
// ---------------------------------------------------------------------------
interface show_frame_uart_tx_if;
    logic [127:0] frame_data;
    logic [4:0]   frame_len;
    logic         frame_valid;
    logic         frame_ready;

    modport master (
        output frame_data,
        output frame_len,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_len,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/show_frame_uart_tx.sv
// ---------------------------------------------------------------------------
// show_frame_uart_tx
// Serializes 128-bit debug/trace frames onto a UART line, most-significant
// meaningful byte first, 8N1 framing (8E1 when SHOW_TX_PARITY_EN is defined,
// which inserts an even-parity bit between data bit 7 and the stop bit).
// Frames offered while a transmission is in progress are discarded and
// counted in a saturating counter; the producer is never stalled.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   DROP_W        width of the dropped-frame counter
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   frame     frame offer channel (show_frame_uart_tx_if.slave)
//   txd       registered UART serial output, idle high
//   busy      high while a frame is being transmitted
//   drop_cnt  saturating count of offered-but-rejected frames
// ---------------------------------------------------------------------------
module show_frame_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DROP_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    show_frame_uart_tx_if.slave  frame,
    output logic                 txd,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef SHOW_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_next;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_idx;
    logic [4:0]          bytes_left;
    logic [127:0]        frame_q;
    logic                txd_q;
    logic [DROP_W-1:0]   drop_cnt_q;

    logic                ready;
    logic                bit_done;
    logic [4:0]          len_clamped;
    logic                start_frame;
    logic [3:0]          byte_sel;
    logic [7:0]          cur_byte;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign ready       = (state == IDLE);
    assign bit_done    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign len_clamped = (frame.frame_len > 5'd16) ? 5'd16 : frame.frame_len;
    assign start_frame = ready && frame.frame_valid && (len_clamped != 5'd0);

    // bytes_left counts down from L to 1; the byte on the wire is the one at
    // index bytes_left-1. A count of 16 wraps to index 15 in 4 bits.
    assign byte_sel = 4'(bytes_left - 5'd1);
    assign cur_byte = frame_q[{byte_sel, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_frame) state_next = START;
            START: if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef SHOW_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef SHOW_TX_PARITY_EN
            PARITY: if (bit_done) state_next = STOP;
`endif
            STOP: begin
                if (bit_done) state_next = (bytes_left > 5'd1) ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload is captured once at acceptance and needs no reset.
    always_ff @(posedge clk) begin
        if (start_frame) frame_q <= frame.frame_data;
    end

    // txd is loaded with the value of the upcoming bit at each bit boundary,
    // so the line changes exactly on the edge that ends the previous bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            bytes_left <= '0;
            txd_q      <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            if (frame.frame_valid && !ready) drop_cnt_q <= sat_inc(drop_cnt_q);

            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (start_frame) begin
                    bytes_left <= len_clamped;
                    txd_q      <= 1'b0;
                end
            end else begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
                if (bit_done) begin
                    case (state)
                        START: begin
                            bit_idx <= 3'd0;
                            txd_q   <= cur_byte[0];
                        end
                        DATA: begin
                            if (bit_idx == 3'd7) begin
`ifdef SHOW_TX_PARITY_EN
                                txd_q <= ^cur_byte;
`else
                                txd_q <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                txd_q   <= cur_byte[bit_idx + 3'd1];
                            end
                        end
`ifdef SHOW_TX_PARITY_EN
                        PARITY: txd_q <= 1'b1;
`endif
                        STOP: begin
                            bytes_left <= bytes_left - 5'd1;
                            txd_q      <= (bytes_left > 5'd1) ? 1'b0 : 1'b1;
                        end
                        default: txd_q <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign txd               = txd_q;
    assign busy              = !ready;
    assign frame.frame_ready = ready;
    assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_show_frame_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_show_frame_uart_tx
// Self-checking bench for show_frame_uart_tx. A reference model derives the
// expected line waveform and byte stream of each frame directly from the
// UART framing rules; directed frames cover the documented cases and a
// randomized loop covers arbitrary payloads, lengths and drop patterns.
// ---------------------------------------------------------------------------
module tb_show_frame_uart_tx;

    localparam int CPB      = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
`ifdef SHOW_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif

    logic              clk;
    logic              reset;
    logic              txd;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    show_frame_uart_tx_if bus ();

    show_frame_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DROP_W       (DROP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .frame    (bus),
        .txd      (txd),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_drop = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        return (len > 16) ? 16 : len;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > DROP_MAX) ? DROP_MAX : a + b;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [127:0] d, input int L, input int i);
        return d[8*(L-1-i) +: 8];
    endfunction

    // Expected line level k cycles after the acceptance edge.
    function automatic logic exp_line(input logic [127:0] d, input int L, input int k);
        int b;
        int pos;
        logic [7:0] v;
        b   = k / CPB;
        pos = b % BITS;
        v   = frame_byte(d, L, b / BITS);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return v[pos-1];
        if (BITS == 11 && pos == 9) return ^v;
        return 1'b1;
    endfunction

    // Expected character, LSB = start bit, MSB = stop bit.
    function automatic logic [BITS-1:0] exp_char(input logic [7:0] v);
`ifdef SHOW_TX_PARITY_EN
        return {1'b1, ^v, v, 1'b0};
`else
        return {1'b1, v, 1'b0};
`endif
    endfunction

    task automatic send_frame(input string tag, input logic [127:0] d, input int len, input bit hold);
        int L;
        int total;
        int errs;
        int busy_cycles;
        logic samples[$];
        logic [BITS-1:0] obs;
        L = clamp_len(len);
        total = L * BITS * CPB;
        @(negedge clk);
        bus.frame_data  = d;
        bus.frame_len   = 5'(len);
        bus.frame_valid = 1'b1;
        @(negedge clk);
        // Scramble the inputs after acceptance: the captured frame must not change.
        bus.frame_data = {$urandom, $urandom, $urandom, $urandom};
        bus.frame_len  = 5'($urandom);
        if (!hold || L == 0) bus.frame_valid = 1'b0;
        errs = 0;
        busy_cycles = 0;
        for (int k = 0; k < total; k++) begin
            samples.push_back(txd);
            if (txd !== exp_line(d, L, k)) errs++;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        bus.frame_valid = 1'b0;
        if (hold && L > 0) exp_drop = sat_add(exp_drop, total);
        check_val({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(total));
        check_val({tag, "_line_errs"}, 64'(errs), 64'd0);
        check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_val({tag, "_ready_end"}, 64'(bus.frame_ready), 64'd1);
        check_val({tag, "_txd_end"}, 64'(txd), 64'd1);
        check_val({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < BITS; j++) obs[j] = samples[(i*BITS + j)*CPB + CPB/2];
            check_val($sformatf("%s_byte%0d", tag, i), 64'(obs), 64'(exp_char(frame_byte(d, L, i))));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.frame_data  = '0;
        bus.frame_len   = '0;
        bus.frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_txd", 64'(txd), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ready", 64'(bus.frame_ready), 64'd1);
        check_val("rst_drop", 64'(drop_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        send_frame("single_80", 128'h80, 1, 1'b0);
        send_frame("twelve", {32'h0, 96'h10_05_3C_00_00000040_8C020000}, 12, 1'b0);
        send_frame("len0", 128'hDEADBEEF, 0, 1'b0);
        send_frame("len20", 128'h0F0E0D0C0B0A09080706050403020100, 20, 1'b0);
        send_frame("drop_2byte", 128'hA55A, 2, 1'b1);
        check_val("drop_80", 64'(drop_cnt), 64'd80);
        send_frame("par_07", 128'h07, 1, 1'b0);
        send_frame("par_03", 128'h03, 1, 1'b0);

        // Reset in the middle of data bit 3 of byte 0xA5 (bit 3 is 0).
        @(negedge clk);
        bus.frame_data  = 128'hA5;
        bus.frame_len   = 5'd1;
        bus.frame_valid = 1'b1;
        @(negedge clk);
        repeat (17) @(negedge clk);
        exp_drop = sat_add(exp_drop, 17);
        check_val("mid_txd_bit3", 64'(txd), 64'd0);
        check_val("mid_drop", 64'(drop_cnt), 64'(exp_drop));
        reset = 1'b1;
        #1;
        bus.frame_valid = 1'b0;
        exp_drop = 0;
        check_val("midrst_txd", 64'(txd), 64'd1);
        check_val("midrst_ready", 64'(bus.frame_ready), 64'd1);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        send_frame("after_rst", 128'h1234_5678, 4, 1'b0);

        // Saturation: two held 16-byte frames overflow the 8-bit counter.
        send_frame("sat_a", {$urandom, $urandom, $urandom, $urandom}, 16, 1'b1);
        send_frame("sat_b", {$urandom, $urandom, $urandom, $urandom}, 16, 1'b1);
        check_val("sat_stuck", 64'(drop_cnt), 64'(DROP_MAX));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_drop = 0;
        for (int n = 0; n < 24; n++) begin
            send_frame($sformatf("rnd%0d", n), {$urandom, $urandom, $urandom, $urandom},
                       int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
